updown_counter_mod: RTL and testbench

- Parametrised synchronous counter: width, modulus, up/down direction, enable, sync load/clear, wrap or saturate per cycle.
- Registered wrap pulse and sticky overflow/underflow flags.
- General-purpose replacement for fixed 4-bit up counters: timers, decade/BCD digits, address generators.
- All state changes on clk rising edge, except async reset.

---
 rtl/updown_counter_mod.sv | 98 +++++++++
 tb/tb_updown_counter_mod.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/updown_counter_mod.sv
// Parametrised up/down counter with modulus, wrap-or-saturate limits,
// registered limit pulse and sticky overflow/underflow flags.
module updown_counter_mod #(
    parameter int unsigned     WIDTH  = 4,
    parameter longint unsigned MODULO = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up_dn,
    input  logic             sat_mode,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             flag_clr,
    output logic [WIDTH-1:0] out,
    output logic             wrap,
    output logic             ovf,
    output logic             unf,
    output logic             at_max,
    output logic             at_zero
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULO - 64'd1);
    localparam logic [WIDTH:0]   ONE_EXT = (WIDTH+1)'(1);

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    logic             count_step;
    logic             up_event;
    logic             dn_event;
    logic [WIDTH:0]   inc_ext;
    logic [WIDTH:0]   dec_ext;
    logic [WIDTH-1:0] load_clamped;

    assign at_max  = (count_q == MAX_VAL);
    assign at_zero = (count_q == '0);

    // A limit event only exists when the enable path actually owns the update.
    assign count_step = en & ~clr & ~load;
    assign up_event   = count_step &  up_dn & at_max;
    assign dn_event   = count_step & ~up_dn & at_zero;

    assign inc_ext      = {1'b0, count_q} + ONE_EXT;
    assign dec_ext      = {1'b0, count_q} - ONE_EXT;
    assign load_clamped = (load_val > MAX_VAL) ? MAX_VAL : load_val;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (load) begin
            count_d = load_clamped;
        end else if (en) begin
            if (up_dn) begin
                if (!at_max)
                    count_d = inc_ext[WIDTH-1:0];
                else if (!sat_mode)
                    count_d = '0;
            end else begin
                if (!at_zero)
                    count_d = dec_ext[WIDTH-1:0];
                else if (!sat_mode)
                    count_d = MAX_VAL;
            end
        end
    end

    // flag_clr clears both flags, but a same-edge limit event re-sets its own flag.
    always_comb begin
        wrap_d = up_event | dn_event;
        ovf_d  = (ovf_q & ~flag_clr) | up_event;
        unf_d  = (unf_q & ~flag_clr) | dn_event;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign out  = count_q;
    assign wrap = wrap_q;
    assign ovf  = ovf_q;
    assign unf  = unf_q;

endmodule

// File: tb/tb_updown_counter_mod.sv
// Bench for updown_counter_mod: a MODULO=10 and a MODULO=16 instance share
// stimulus and are checked against an integer-arithmetic reference model.
module tb_updown_counter_mod;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0, up_dn = 1'b1, sat_mode = 1'b0;
    logic       clr = 1'b0, load = 1'b0, flag_clr = 1'b0;
    logic [3:0] load_val = '0;

    logic [3:0] out10, out16;
    logic       wrap10, ovf10, unf10, max10, zero10;
    logic       wrap16, ovf16, unf16, max16, zero16;

    int n_tests = 0;
    int n_fail  = 0;

    int m_cnt [2];
    bit m_wrap[2];
    bit m_ovf [2];
    bit m_unf [2];
    int m_mod [2] = '{10, 16};

    always #5 clk = ~clk;

    updown_counter_mod #(.WIDTH(4), .MODULO(10)) dut10 (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .sat_mode(sat_mode),
        .clr(clr), .load(load), .load_val(load_val), .flag_clr(flag_clr),
        .out(out10), .wrap(wrap10), .ovf(ovf10), .unf(unf10),
        .at_max(max10), .at_zero(zero10)
    );

    updown_counter_mod #(.WIDTH(4), .MODULO(16)) dut16 (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .sat_mode(sat_mode),
        .clr(clr), .load(load), .load_val(load_val), .flag_clr(flag_clr),
        .out(out16), .wrap(wrap16), .ovf(ovf16), .unf(unf16),
        .at_max(max16), .at_zero(zero16)
    );

    // Packed view: {out, wrap, ovf, unf, at_max, at_zero}
    function automatic logic [8:0] obs(int i);
        if (i == 0) return {out10, wrap10, ovf10, unf10, max10, zero10};
        return {out16, wrap16, ovf16, unf16, max16, zero16};
    endfunction

    function automatic logic [8:0] expv(int i);
        logic [3:0] c;
        c = 4'(m_cnt[i]);
        return {c, m_wrap[i], m_ovf[i], m_unf[i],
                m_cnt[i] == m_mod[i] - 1, m_cnt[i] == 0};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_cnt[i] = 0; m_wrap[i] = 0; m_ovf[i] = 0; m_unf[i] = 0;
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            int  md, c, lv;
            bit  hit_up, hit_dn;
            md = m_mod[i];
            c  = m_cnt[i];
            lv = int'(load_val);
            hit_up = en && !clr && !load &&  up_dn && (c == md - 1);
            hit_dn = en && !clr && !load && !up_dn && (c == 0);
            if (clr)                m_cnt[i] = 0;
            else if (load)          m_cnt[i] = (lv >= md) ? md - 1 : lv;
            else if (en && up_dn)   m_cnt[i] = (sat_mode && hit_up) ? c : (c + 1) % md;
            else if (en)            m_cnt[i] = (sat_mode && hit_dn) ? c : (c + md - 1) % md;
            m_wrap[i] = hit_up || hit_dn;
            if (flag_clr) begin
                m_ovf[i] = 0; m_unf[i] = 0;
            end
            if (hit_up) m_ovf[i] = 1;
            if (hit_dn) m_unf[i] = 1;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        en = 0; clr = 0; load = 0; flag_clr = 0;
    endtask

    task automatic test_reset();
        model_reset();
        #20;
        for (int i = 0; i < 2; i++) begin
            n_tests++;
            if (obs(i) !== 9'b0000_0000_1) begin
                n_fail++;
                $display("FAIL reset[%0d]: got %b expected %b", i, obs(i), 9'b0000_0000_1);
            end
        end
        reset = 0;
    endtask

    task automatic test_up_wrap();
        int exp_seq[12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
        en = 1; up_dn = 1; sat_mode = 0;
        for (int k = 0; k < 12; k++) begin
            logic [8:0] e;
            tick();
            e = {4'(exp_seq[k]), k == 9, k >= 9, 1'b0, exp_seq[k] == 9, exp_seq[k] == 0};
            n_tests++;
            if (obs(0) !== e) begin
                n_fail++;
                $display("FAIL up_wrap step %0d: got %b expected %b", k, obs(0), e);
            end
            n_tests++;
            if (obs(1) !== expv(1)) begin
                n_fail++;
                $display("FAIL up_wrap16 step %0d: got %b expected %b", k, obs(1), expv(1));
            end
        end
        idle_inputs();
    endtask

    task automatic test_down_wrap_flag_clr();
        int exp_seq[4] = '{2, 1, 0, 9};
        load_val = 4'd2; load = 1;
        for (int k = 0; k < 4; k++) begin
            tick();
            load = 0; en = 1; up_dn = 0;
            n_tests++;
            if (out10 !== 4'(exp_seq[k]) || wrap10 !== (k == 3)) begin
                n_fail++;
                $display("FAIL down_wrap step %0d: got out=%0d wrap=%b expected out=%0d wrap=%b",
                         k, out10, wrap10, exp_seq[k], k == 3);
            end
        end
        n_tests++;
        if (unf10 !== 1'b1 || ovf10 !== 1'b1) begin
            n_fail++;
            $display("FAIL down_flags: got unf=%b ovf=%b expected unf=1 ovf=1", unf10, ovf10);
        end
        n_tests++;
        if (obs(1) !== expv(1)) begin
            n_fail++;
            $display("FAIL down_wrap16: got %b expected %b", obs(1), expv(1));
        end
        en = 0; flag_clr = 1;
        tick();
        flag_clr = 0;
        n_tests++;
        if (unf10 !== 1'b0 || ovf10 !== 1'b0 || out10 !== 4'd9) begin
            n_fail++;
            $display("FAIL flag_clr: got unf=%b ovf=%b out=%0d expected unf=0 ovf=0 out=9",
                     unf10, ovf10, out10);
        end
        idle_inputs();
    endtask

    task automatic test_saturation();
        int exp_seq[4] = '{8, 9, 9, 9};
        sat_mode = 1; load_val = 4'd8; load = 1;
        for (int k = 0; k < 4; k++) begin
            tick();
            load = 0; en = 1; up_dn = 1;
            n_tests++;
            if (out10 !== 4'(exp_seq[k]) || wrap10 !== (k >= 2) || ovf10 !== (k >= 2)) begin
                n_fail++;
                $display("FAIL sat_up step %0d: got out=%0d wrap=%b ovf=%b expected out=%0d wrap=%b ovf=%b",
                         k, out10, wrap10, ovf10, exp_seq[k], k >= 2, k >= 2);
            end
        end
        en = 0; load_val = 4'd1; load = 1;
        tick();
        load = 0; en = 1; up_dn = 0;
        for (int k = 0; k < 2; k++) begin
            tick();
            n_tests++;
            if (out10 !== 4'd0 || wrap10 !== (k == 1) || unf10 !== (k == 1)) begin
                n_fail++;
                $display("FAIL sat_down step %0d: got out=%0d wrap=%b unf=%b expected out=0 wrap=%b unf=%b",
                         k, out10, wrap10, unf10, k == 1, k == 1);
            end
        end
        n_tests++;
        if (obs(1) !== expv(1)) begin
            n_fail++;
            $display("FAIL sat16: got %b expected %b", obs(1), expv(1));
        end
        idle_inputs();
        sat_mode = 0;
    endtask

    task automatic test_priority_clamp();
        clr = 1; load = 1; en = 1; load_val = 4'd5;
        tick();
        n_tests++;
        if (out10 !== 4'd0 || out16 !== 4'd0) begin
            n_fail++;
            $display("FAIL clr_over_load: got %0d/%0d expected 0/0", out10, out16);
        end
        clr = 0; load = 1; en = 1; up_dn = 1; load_val = 4'd13;
        tick();
        n_tests++;
        if (out10 !== 4'd9 || wrap10 !== 1'b0 || out16 !== 4'd13 || wrap16 !== 1'b0) begin
            n_fail++;
            $display("FAIL load_clamp: got %0d/%0d wrap %b/%b expected 9/13 wrap 0/0",
                     out10, out16, wrap10, wrap16);
        end
        idle_inputs();
        for (int k = 0; k < 3; k++) begin
            tick();
            n_tests++;
            if (out10 !== 4'd9 || out16 !== 4'd13 || wrap10 !== 1'b0) begin
                n_fail++;
                $display("FAIL hold step %0d: got %0d/%0d wrap=%b expected 9/13 wrap=0",
                         k, out10, out16, wrap10);
            end
        end
    endtask

    task automatic test_async_reset();
        load_val = 4'd9; load = 1;
        tick();
        load = 0; en = 1; up_dn = 1;
        tick();
        en = 0; load_val = 4'd6; load = 1;
        tick();
        load = 0;
        n_tests++;
        if (out10 !== 4'd6 || ovf10 !== 1'b1) begin
            n_fail++;
            $display("FAIL async_setup: got out=%0d ovf=%b expected out=6 ovf=1", out10, ovf10);
        end
        #2 reset = 1;
        #1;
        model_reset();
        for (int i = 0; i < 2; i++) begin
            n_tests++;
            if (obs(i) !== 9'b0000_0000_1) begin
                n_fail++;
                $display("FAIL async_reset[%0d]: got %b expected %b", i, obs(i), 9'b0000_0000_1);
            end
        end
        #1 reset = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_full_range();
        en = 0; flag_clr = 1;
        tick();
        flag_clr = 0; load_val = 4'd15; load = 1;
        tick();
        load = 0; en = 1; up_dn = 1; sat_mode = 0; flag_clr = 1;
        tick();
        flag_clr = 0;
        n_tests++;
        if (out16 !== 4'd0 || wrap16 !== 1'b1 || ovf16 !== 1'b1 || unf16 !== 1'b0) begin
            n_fail++;
            $display("FAIL full_up: got out=%0d wrap=%b ovf=%b unf=%b expected out=0 wrap=1 ovf=1 unf=0",
                     out16, wrap16, ovf16, unf16);
        end
        up_dn = 0;
        tick();
        n_tests++;
        if (out16 !== 4'd15 || wrap16 !== 1'b1 || ovf16 !== 1'b1 || unf16 !== 1'b1) begin
            n_fail++;
            $display("FAIL full_down: got out=%0d wrap=%b ovf=%b unf=%b expected out=15 wrap=1 ovf=1 unf=1",
                     out16, wrap16, ovf16, unf16);
        end
        n_tests++;
        if (obs(0) !== expv(0)) begin
            n_fail++;
            $display("FAIL full10: got %b expected %b", obs(0), expv(0));
        end
        idle_inputs();
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            en       = ($urandom_range(0, 3) != 0);
            up_dn    = 1'($urandom);
            sat_mode = ($urandom_range(0, 3) == 0);
            clr      = ($urandom_range(0, 19) == 0);
            load     = ($urandom_range(0, 11) == 0);
            load_val = 4'($urandom);
            flag_clr = ($urandom_range(0, 9) == 0);
            tick();
            for (int i = 0; i < 2; i++) begin
                n_tests++;
                if (obs(i) !== expv(i)) begin
                    n_fail++;
                    $display("FAIL random[%0d] step %0d: got %b expected %b", i, k, obs(i), expv(i));
                end
            end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_up_wrap();
        test_down_wrap_flag_clr();
        test_saturation();
        test_priority_clamp();
        test_async_reset();
        test_full_range();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
